// File: rtl/cache_pkg.sv
// Shared types, field widths and address slicing for the cache sequencing FSM.
// Included by cache_ctrl and cache_burst_cnt via import cache_pkg::*.
package cache_pkg;

    localparam int AWIDTH       = 32;
    localparam int NWAYS        = 4;
    localparam int WAY_WIDTH    = 2;
    localparam int INDEX_WIDTH  = 7;
    localparam int TAG_WIDTH    = 19;
    localparam int OFFSET_WIDTH = 6;
    localparam int BEATS        = 8;
    localparam int BEAT_WIDTH   = 3;
    localparam int BASE_WIDTH   = AWIDTH - OFFSET_WIDTH;

    localparam int INDEX_LSB = OFFSET_WIDTH;
    localparam int INDEX_MSB = OFFSET_WIDTH + INDEX_WIDTH - 1;
    localparam int TAG_LSB   = INDEX_MSB + 1;
    localparam int TAG_MSB   = AWIDTH - 1;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL,
        UPDATE,
        RESP
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cache_burst_cnt.sv
// Beat counter for writeback/refill bursts; advances on each accepted beat
// and flags the final beat of a line. Natural 3-bit wrap returns it to 0.
module cache_burst_cnt
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    output logic [BEAT_WIDTH-1:0] beat,
    output logic                  last
);

    // NOTE: sequential state always uses non-blocking assignment so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat <= '0;
        end else if (inc) begin
            beat <= beat + BEAT_WIDTH'(1);
        end
    end

    assign last = (beat == BEAT_WIDTH'(BEATS - 1));

endmodule

// File: rtl/cache_ctrl.sv
// Load/store sequencer for the 4-way write-back, write-allocate cache arrays.
// Optional performance counters are built when CACHE_PERF_EN is defined.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [AWIDTH-1:0]      cpu_addr,
    output logic                   cpu_ready,
    output logic                   cpu_done,
    output logic                   cpu_hit,
    output logic                   arr_lookup,
    output logic [INDEX_WIDTH-1:0] arr_index,
    input  logic                   arr_hit,
    input  logic [WAY_WIDTH-1:0]   arr_hit_way,
    input  logic [WAY_WIDTH-1:0]   arr_victim_way,
    input  logic                   arr_victim_dirty,
    input  logic [TAG_WIDTH-1:0]   arr_victim_tag,
    output logic                   arr_wb_rd,
    output logic                   arr_fill_we,
    output logic [WAY_WIDTH-1:0]   arr_way,
    output logic [BEAT_WIDTH-1:0]  arr_beat,
    output logic                   arr_tag_we,
    output logic                   arr_word_we,
    output logic                   arr_lru_upd,
    output logic                   mem_rd_en,
    output logic                   mem_wr_en,
    output logic [AWIDTH-1:0]      mem_addr,
    input  logic                   mem_ack,
    output logic [31:0]            hit_cnt,
    output logic [31:0]            miss_cnt,
    output logic [31:0]            wb_cnt
);

    state_t                 state;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [INDEX_WIDTH-1:0] index_q;
    logic                   we_q;
    logic                   hit_q;
    logic [BASE_WIDTH-1:0]  base_q;
    logic                   burst_inc;
    logic                   burst_last;

    // Byte offset within the line is irrelevant to line-granular sequencing.
    logic unused_offset;
    assign unused_offset = ^cpu_addr[OFFSET_WIDTH-1:0];

    assign burst_inc = mem_ack && (state == WRITEBACK || state == REFILL);

    cache_burst_cnt u_burst_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (burst_inc),
        .beat  (arr_beat),
        .last  (burst_last)
    );

    assign cpu_ready   = (state == IDLE);
    assign arr_fill_we = (state == REFILL) && mem_ack;
    assign arr_index   = index_q;
    assign mem_addr    = {base_q, arr_beat, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tag_q       <= '0;
            index_q     <= '0;
            we_q        <= 1'b0;
            hit_q       <= 1'b0;
            base_q      <= '0;
            arr_way     <= '0;
            arr_lookup  <= 1'b0;
            arr_wb_rd   <= 1'b0;
            arr_tag_we  <= 1'b0;
            arr_word_we <= 1'b0;
            arr_lru_upd <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            cpu_done    <= 1'b0;
            cpu_hit     <= 1'b0;
        end else begin
            arr_lookup  <= 1'b0;
            arr_tag_we  <= 1'b0;
            arr_word_we <= 1'b0;
            arr_lru_upd <= 1'b0;
            cpu_done    <= 1'b0;
            cpu_hit     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        tag_q      <= cpu_addr[TAG_MSB:TAG_LSB];
                        index_q    <= cpu_addr[INDEX_MSB:INDEX_LSB];
                        we_q       <= cpu_we;
                        arr_lookup <= 1'b1;
                        state      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    hit_q <= arr_hit;
                    if (arr_hit) begin
                        arr_way <= arr_hit_way;
                        state   <= UPDATE;
                    end else if (arr_victim_dirty) begin
                        arr_way   <= arr_victim_way;
                        base_q    <= {arr_victim_tag, index_q};
                        mem_wr_en <= 1'b1;
                        arr_wb_rd <= 1'b1;
                        state     <= WRITEBACK;
                    end else begin
                        arr_way   <= arr_victim_way;
                        base_q    <= {tag_q, index_q};
                        mem_rd_en <= 1'b1;
                        state     <= REFILL;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack && burst_last) begin
                        mem_wr_en <= 1'b0;
                        arr_wb_rd <= 1'b0;
                        mem_rd_en <= 1'b1;
                        base_q    <= {tag_q, index_q};
                        state     <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ack && burst_last) begin
                        mem_rd_en  <= 1'b0;
                        arr_tag_we <= 1'b1;
                        state      <= UPDATE;
                    end
                end
                UPDATE: begin
                    arr_lru_upd <= 1'b1;
                    arr_word_we <= we_q;
                    state       <= RESP;
                end
                RESP: begin
                    cpu_done <= 1'b1;
                    cpu_hit  <= hit_q;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_PERF_EN
    // Counters observe the single LOOKUP cycle of each access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else if (state == LOOKUP) begin
            if (arr_hit) begin
                hit_cnt <= sat_inc(hit_cnt);
            end else begin
                miss_cnt <= sat_inc(miss_cnt);
                if (arr_victim_dirty) begin
                    wb_cnt <= sat_inc(wb_cnt);
                end
            end
        end
    end
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
    assign wb_cnt   = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: the bench plays the cache arrays and memory,
// predicts each access with a tag/LRU reference model, and checks bursts at cpu_done.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr;
    logic        cpu_ready, cpu_done, cpu_hit;
    logic        arr_lookup;
    logic [6:0]  arr_index;
    logic        arr_hit;
    logic [1:0]  arr_hit_way, arr_victim_way;
    logic        arr_victim_dirty;
    logic [18:0] arr_victim_tag;
    logic        arr_wb_rd, arr_fill_we, arr_tag_we, arr_word_we, arr_lru_upd;
    logic [1:0]  arr_way;
    logic [2:0]  arr_beat;
    logic        mem_rd_en, mem_wr_en, mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] hit_cnt, miss_cnt, wb_cnt;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_hit(cpu_hit),
        .arr_lookup(arr_lookup), .arr_index(arr_index),
        .arr_hit(arr_hit), .arr_hit_way(arr_hit_way),
        .arr_victim_way(arr_victim_way), .arr_victim_dirty(arr_victim_dirty),
        .arr_victim_tag(arr_victim_tag),
        .arr_wb_rd(arr_wb_rd), .arr_fill_we(arr_fill_we), .arr_way(arr_way),
        .arr_beat(arr_beat), .arr_tag_we(arr_tag_we), .arr_word_we(arr_word_we),
        .arr_lru_upd(arr_lru_upd),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    typedef struct {
        logic        hit;
        logic        we;
        logic [1:0]  way;
        logic        wb;
        logic [31:0] wb_base;
        logic [31:0] fill_base;
        int          acc_cyc;
    } exp_t;

    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int gap_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference cache: tag/valid/dirty per way, LRU by last-use timestamp.
    logic [18:0] m_tag   [128][4];
    bit          m_val   [128][4];
    bit          m_dirty [128][4];
    int          m_stamp [128][4];
    int          m_now;
    int          m_hits, m_misses, m_wbs;

    task automatic model_reset();
        for (int s = 0; s < 128; s++) begin
            for (int w = 0; w < 4; w++) begin
                m_tag[s][w] = '0; m_val[s][w] = 0; m_dirty[s][w] = 0; m_stamp[s][w] = 0;
            end
        end
        m_now = 0; m_hits = 0; m_misses = 0; m_wbs = 0;
    endtask

    // Memory: acks only while a burst is requested; noise otherwise.
    initial begin
        int ack_ctr;
        ack_ctr = 0;
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                mem_ack = 1'b0;
            end else if (mem_rd_en || mem_wr_en) begin
                ack_ctr++;
                mem_ack = (gap_mode != 0) ? ((ack_ctr % 4) == 0) : 1'b1;
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
            end
        end
    end

    int mon_wb, mon_fill, mon_fill_we, mon_tag_we, mon_lru_cnt, mon_lru_way, mon_word_we;
    bit mon_overlap;

    task automatic mon_clear();
        mon_wb = 0; mon_fill = 0; mon_fill_we = 0; mon_tag_we = 0;
        mon_lru_cnt = 0; mon_lru_way = 0; mon_word_we = 0; mon_overlap = 0;
    endtask

    // Monitor: samples mid-low-phase, accumulates activity, pops on cpu_done.
    initial begin
        exp_t cur;
        mon_clear();
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1) begin
                if (mem_rd_en && mem_wr_en) mon_overlap = 1;
                if (sb_q.size() > 0) begin
                    cur = sb_q[0];
                    if (mem_wr_en && mem_ack) begin
                        check("wb_addr", mem_addr, cur.wb_base + 32'(mon_wb * 8));
                        check("wb_rd", 32'(arr_wb_rd), 32'd1);
                        mon_wb++;
                    end
                    if (mem_rd_en && mem_ack) begin
                        check("fill_addr", mem_addr, cur.fill_base + 32'(mon_fill * 8));
                        mon_fill++;
                    end
                    if (arr_fill_we) mon_fill_we++;
                    if (arr_tag_we) mon_tag_we++;
                    if (arr_word_we) mon_word_we++;
                    if (arr_lru_upd) begin
                        mon_lru_cnt++;
                        mon_lru_way = int'(arr_way);
                    end
                    if (cpu_done) begin
                        void'(sb_q.pop_front());
                        check("cpu_hit", 32'(cpu_hit), 32'(cur.hit));
                        check("wb_beats", 32'(mon_wb), cur.wb ? 32'd8 : 32'd0);
                        check("fill_beats", 32'(mon_fill), cur.hit ? 32'd0 : 32'd8);
                        check("fill_we", 32'(mon_fill_we), cur.hit ? 32'd0 : 32'd8);
                        check("tag_we", 32'(mon_tag_we), cur.hit ? 32'd0 : 32'd1);
                        check("lru_upd", 32'(mon_lru_cnt), 32'd1);
                        check("lru_way", 32'(mon_lru_way), 32'(cur.way));
                        check("word_we", 32'(mon_word_we), 32'(cur.we));
                        check("en_overlap", 32'(mon_overlap), 32'd0);
                        if (cur.hit) check("hit_latency", 32'(cyc - cur.acc_cyc), 32'd4);
                        mon_clear();
                    end
                end else begin
                    check("spurious_done", 32'(cpu_done), 32'd0);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input logic we);
        exp_t e;
        int t, hw, v;
        logic [6:0]  idx;
        logic [18:0] tag;
        t = 0;
        @(negedge clk);
        while ((sb_q.size() != 0 || !cpu_ready) && t < 500) begin
            @(negedge clk);
            t++;
        end
        idx = addr[12:6];
        tag = addr[31:13];
        hw = -1;
        for (int w = 0; w < 4; w++)
            if (m_val[idx][w] && m_tag[idx][w] == tag) hw = w;
        v = 0;
        for (int w = 1; w < 4; w++)
            if (m_stamp[idx][w] < m_stamp[idx][v]) v = w;
        arr_hit          = (hw >= 0);
        arr_hit_way      = 2'((hw >= 0) ? hw : 0);
        arr_victim_way   = 2'(v);
        arr_victim_dirty = m_val[idx][v] && m_dirty[idx][v];
        arr_victim_tag   = m_tag[idx][v];
        e.hit       = (hw >= 0);
        e.we        = we;
        e.way       = 2'((hw >= 0) ? hw : v);
        e.wb        = !e.hit && arr_victim_dirty;
        e.wb_base   = {m_tag[idx][v], idx, 6'b0};
        e.fill_base = {tag, idx, 6'b0};
        e.acc_cyc   = cyc;
        m_now++;
        if (e.hit) begin
            m_hits++;
            if (we) m_dirty[idx][hw] = 1;
            m_stamp[idx][hw] = m_now;
        end else begin
            m_misses++;
            if (e.wb) m_wbs++;
            m_tag[idx][v] = tag; m_val[idx][v] = 1; m_dirty[idx][v] = we;
            m_stamp[idx][v] = m_now;
        end
        sb_q.push_back(e);
        cpu_req = 1'b1; cpu_addr = addr; cpu_we = we;
        @(negedge clk);
        cpu_req = 1'b0; cpu_addr = $urandom; cpu_we = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            check("done_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic access(input logic [31:0] addr, input logic we);
        issue(addr, we);
        wait_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        model_reset();
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        arr_hit = 1'b0; arr_hit_way = '0; arr_victim_way = '0;
        arr_victim_dirty = 1'b0; arr_victim_tag = '0;
        repeat (3) @(negedge clk);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd1);
        check("rst_cpu_done", 32'(cpu_done), 32'd0);
        check("rst_lookup", 32'(arr_lookup), 32'd0);
        check("rst_mem_en", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_beat", 32'(arr_beat), 32'd0);
        rst_n = 1'b1;

        // Directed: clean miss, set fill, hit, dirty-victim writeback at 0xA040.
        access(32'h0000_2040, 1'b0);
        access(32'h0000_A040, 1'b1);
        access(32'h0000_C048, 1'b1);
        access(32'h0000_E050, 1'b1);
        access(32'h0000_2058, 1'b0);
        access(32'h0001_0040, 1'b1);
        access(32'h0000_C040, 1'b0);
        gap_mode = 1;
        access(32'h0001_2040, 1'b1);
        gap_mode = 0;

        for (int n = 0; n < 60; n++) begin
            logic [18:0] tg;
            logic [6:0]  ix;
            logic [5:0]  of;
            tg = 19'($urandom_range(0, 5));
            ix = 7'($urandom_range(0, 1));
            of = 6'($urandom);
            gap_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            access({tg, ix, of}, 1'($urandom_range(0, 1)));
        end
        gap_mode = 0;

`ifdef CACHE_PERF_EN
        check("hit_cnt", hit_cnt, 32'(m_hits));
        check("miss_cnt", miss_cnt, 32'(m_misses));
        check("wb_cnt", wb_cnt, 32'(m_wbs));
`endif

        // Reset in the middle of a refill burst.
        issue(32'h8246_80C0, 1'b0);
        t = 0;
        while (mon_fill < 4 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("reach_beat4", 32'(arr_beat), 32'd4);
        rst_n = 1'b0;
        #1;
        check("abort_rd_en", 32'(mem_rd_en), 32'd0);
        check("abort_fill_we", 32'(arr_fill_we), 32'd0);
        check("abort_ready", 32'(cpu_ready), 32'd1);
        sb_q.delete();
        mon_clear();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(cpu_ready), 32'd1);
        check("post_rst_mem_en", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
`ifdef CACHE_PERF_EN
        check("post_rst_hit_cnt", hit_cnt, 32'd0);
`endif
        access(32'h0000_4080, 1'b1);
        access(32'h0000_4080, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
